// File: rtl/maze_motion_model.sv
// rtl/maze_motion_model.sv - grid plant model driven by movement_sel/state_control, regenerates sensor flags
// Optional macro STEP_COUNTER_EN enables the saturating completed-step counter on step_count.
module maze_motion_model #(
    parameter int GRID_W      = 8,
    parameter int GRID_H      = 8,
    parameter int START_X     = 0,
    parameter int START_Y     = 0,
    parameter int GOAL_X      = 7,
    parameter int GOAL_Y      = 7,
    parameter int MOVE_CYCLES = 4,
    parameter logic [GRID_W*GRID_H-1:0] OBST_MAP = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  movement_sel,
    input  logic [1:0]  state_control,
    output logic [3:0]  sensor,
    output logic [3:0]  pos_x,
    output logic [3:0]  pos_y,
    output logic        busy,
    output logic        collision,
    output logic        cmd_error,
    output logic        at_goal,
    output logic [15:0] step_count
);

    localparam int MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam logic [MCW-1:0] MC_LAST = MCW'(MOVE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CHECK, MOVE, SETTLE} state_t;

    state_t         state;
    logic [3:0]     dir;
    logic [1:0]     steps;
    logic [MCW-1:0] mcnt;
    logic [3:0]     nbr;
    logic           tgt_blocked;
    logic           step_done;

    // Out-of-grid cells count as walls so the edges need no special handling.
    function automatic logic cell_blocked(input int x, input int y);
        logic [GRID_W*GRID_H-1:0] m;
        if (x < 0 || y < 0 || x >= GRID_W || y >= GRID_H) return 1'b1;
        m = OBST_MAP >> (y * GRID_W + x);
        return m[0];
    endfunction

    function automatic logic [3:0] sense_at(input logic [3:0] px, input logic [3:0] py);
        int x;
        int y;
        x = int'(px);
        y = int'(py);
        return {cell_blocked(x - 1, y), cell_blocked(x, y - 1),
                cell_blocked(x + 1, y), cell_blocked(x, y + 1)};
    endfunction

    assign nbr = sense_at(pos_x, pos_y);

    always_comb begin
        tgt_blocked = nbr[1];
        case (dir)
            4'd1:    tgt_blocked = nbr[3];
            4'd2:    tgt_blocked = nbr[2];
            4'd3:    tgt_blocked = nbr[0];
            default: tgt_blocked = nbr[1];
        endcase
    end

    assign step_done = (state == MOVE) && (mcnt == MC_LAST);
    assign at_goal   = (pos_x == 4'(GOAL_X)) && (pos_y == 4'(GOAL_Y));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pos_x     <= 4'(START_X);
            pos_y     <= 4'(START_Y);
            sensor    <= sense_at(4'(START_X), 4'(START_Y));
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            collision <= 1'b0;
            cmd_error <= 1'b0;
            dir       <= 4'd0;
            steps     <= 2'd0;
            mcnt      <= '0;
        end else begin
            collision <= 1'b0;
            cmd_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        dir       <= movement_sel;
                        state     <= SETTLE;
                        if (movement_sel >= 4'd1 && movement_sel <= 4'd4) begin
                            if (state_control == 2'd0) begin
                                steps <= 2'd1;
                                state <= CHECK;
                            end else if (state_control == 2'd1) begin
                                steps <= 2'd2;
                                state <= CHECK;
                            end
                        end else if (movement_sel != 4'd0) begin
                            cmd_error <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    mcnt <= '0;
                    if (tgt_blocked) begin
                        collision <= 1'b1;
                        steps     <= 2'd0;
                        state     <= SETTLE;
                    end else begin
                        state <= MOVE;
                    end
                end
                MOVE: begin
                    if (step_done) begin
                        case (dir)
                            4'd1:    pos_x <= pos_x - 4'd1;
                            4'd2:    pos_y <= pos_y - 4'd1;
                            4'd3:    pos_y <= pos_y + 4'd1;
                            default: pos_x <= pos_x + 4'd1;
                        endcase
                        steps <= steps - 2'd1;
                        state <= (steps > 2'd1) ? CHECK : SETTLE;
                    end else begin
                        mcnt <= mcnt + 1'b1;
                    end
                end
                default: begin
                    sensor    <= nbr;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef STEP_COUNTER_EN
    logic [15:0] step_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt_q <= 16'h0000;
        end else if (step_done && step_cnt_q != 16'hFFFF) begin
            step_cnt_q <= step_cnt_q + 16'd1;
        end
    end

    assign step_count = step_cnt_q;
`else
    assign step_count = 16'h0000;
`endif

endmodule
